// File: rtl/axis_pkt_checker.sv
// AXI-Stream packet checker: verifies the per-beat data pattern, tkeep shape and
// declared byte length of each packet, with saturating counters and sticky error flags.
module axis_pkt_checker #(
  parameter int P_MAX_BEATS  = 256,
  parameter bit P_THROTTLE   = 1'b0,
  parameter bit P_CHECK_DATA = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic [63:0] s_axis_tdata,
  input  logic [31:0] s_axis_tuser,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        o_pkt_done,
  output logic        o_pkt_err,
  output logic [15:0] o_pkt_cnt,
  output logic [15:0] o_err_cnt,
  output logic [15:0] o_last_len,
  output logic [3:0]  o_err_flags
);

  typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_DROP} state_e;

  state_e      state_q, state_d;
  logic [15:0] k_q, k_d;
  logic [15:0] decl_q, decl_d;
  logic [15:0] len_q, len_d;
  logic [3:0]  err_q, err_d;
  logic [1:0]  thr_q, thr_d;
  logic        tready_q, tready_d;
  logic        done_q, done_d;
  logic        pkt_err_q, pkt_err_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] last_len_q, last_len_d;
  logic [3:0]  flags_q, flags_d;

  logic        accept, first, keep_bad, data_bad, len_bad, oversize;
  logic [15:0] beat_k, len_beat, decl_cur;
  logic [3:0]  keep_pop, err_beat;

  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser[31:16];

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; that is what keeps this combinational (no latches).
  always_comb begin
    accept   = s_axis_tvalid & tready_q;
    first    = (state_q == ST_IDLE);
    beat_k   = first ? 16'd1 : k_q + 16'd1;
    keep_pop = 4'($countones(s_axis_tkeep));
    if (s_axis_tlast) begin
      keep_bad = !(s_axis_tkeep inside {8'hFF, 8'hFE, 8'hFC, 8'hF8,
                                        8'hF0, 8'hE0, 8'hC0, 8'h80});
    end else begin
      keep_bad = (s_axis_tkeep != 8'hFF);
    end
    data_bad = P_CHECK_DATA && (s_axis_tdata != {4{beat_k}});
    len_beat = (first ? 16'd0 : len_q) + (s_axis_tlast ? {12'd0, keep_pop} : 16'd8);
    decl_cur = first ? s_axis_tuser[15:0] : decl_q;
    len_bad  = s_axis_tlast && (len_beat != decl_cur);
    oversize = (state_q == ST_BODY) && !s_axis_tlast && (beat_k == 16'(P_MAX_BEATS));
    // Dropped beats carry no checks; the packet keeps the bits gathered so far.
    err_beat = (state_q == ST_DROP) ? err_q
             : ((first ? 4'd0 : err_q) | {oversize, len_bad, keep_bad, data_bad});

    state_d    = state_q;
    k_d        = k_q;
    decl_d     = decl_q;
    len_d      = len_q;
    err_d      = err_q;
    thr_d      = thr_q + 2'd1;
    tready_d   = !(P_THROTTLE && (thr_d == 2'd3));
    done_d     = 1'b0;
    pkt_err_d  = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;
    last_len_d = last_len_q;
    flags_d    = flags_q;

    if (accept) begin
      if (state_q != ST_DROP) begin
        k_d    = beat_k;
        decl_d = decl_cur;
        len_d  = len_beat;
        err_d  = err_beat;
      end
      case (state_q)
        ST_IDLE: state_d = s_axis_tlast ? ST_IDLE : ST_BODY;
        ST_BODY: state_d = s_axis_tlast ? ST_IDLE : (oversize ? ST_DROP : ST_BODY);
        default: state_d = s_axis_tlast ? ST_IDLE : ST_DROP;
      endcase
      if (s_axis_tlast) begin
        done_d     = 1'b1;
        pkt_err_d  = |err_beat;
        last_len_d = (state_q == ST_DROP) ? len_q : len_beat;
        flags_d    = flags_q | err_beat;
        if (pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
        if ((|err_beat) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
      end
    end

    // Clear beats a simultaneous completion: that packet still pulses done but is not counted.
    if (i_clr) begin
      pkt_cnt_d = 16'd0;
      err_cnt_d = 16'd0;
      flags_d   = 4'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      decl_q     <= '0;
      len_q      <= '0;
      err_q      <= '0;
      thr_q      <= '0;
      tready_q   <= 1'b0;
      done_q     <= 1'b0;
      pkt_err_q  <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      last_len_q <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      decl_q     <= decl_d;
      len_q      <= len_d;
      err_q      <= err_d;
      thr_q      <= thr_d;
      tready_q   <= tready_d;
      done_q     <= done_d;
      pkt_err_q  <= pkt_err_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      last_len_q <= last_len_d;
      flags_q    <= flags_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign o_pkt_done    = done_q;
  assign o_pkt_err     = pkt_err_q;
  assign o_pkt_cnt     = pkt_cnt_q;
  assign o_err_cnt     = err_cnt_q;
  assign o_last_len    = last_len_q;
  assign o_err_flags   = flags_q;

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Scoreboard bench for axis_pkt_checker: an unthrottled and a throttled instance share
// one stimulus bus; a packet-level reference model predicts each completion.
module tb_axis_pkt_checker;

  localparam int MAXB = 256;

  typedef struct {
    logic        err;
    logic [3:0]  bits;
    logic [15:0] len;
    bit          len_chk;
    logic [15:0] pcnt;
    logic [15:0] ecnt;
    logic [3:0]  flags;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic        tlast = 1'b0, tvalid = 1'b0, sel = 1'b0;
  logic [63:0] tdata = '0;
  logic [31:0] tuser = '0;
  logic [7:0]  tkeep = '0;
  logic        a_tvalid, b_tvalid;

  logic        a_tready, a_done, a_pkt_err, b_tready, b_done, b_pkt_err;
  logic [15:0] a_pkt_cnt, a_err_cnt, a_last_len, b_pkt_cnt, b_err_cnt, b_last_len;
  logic [3:0]  a_flags, b_flags;

  int checks = 0, errors = 0, cyc = 0;
  exp_t sbq[$];
  int   due_q[$];
  logic [63:0] pd[$];
  logic [7:0]  pk[$];
  logic [15:0] m_pcnt[2], m_ecnt[2];
  logic [3:0]  m_flags[2];
  logic [7:0]  kv[8] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

  assign a_tvalid = tvalid & ~sel;
  assign b_tvalid = tvalid & sel;

  axis_pkt_checker #(.P_MAX_BEATS(MAXB), .P_THROTTLE(1'b0), .P_CHECK_DATA(1'b1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_clr(clr),
    .s_axis_tdata(tdata), .s_axis_tuser(tuser), .s_axis_tkeep(tkeep),
    .s_axis_tlast(tlast), .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready),
    .o_pkt_done(a_done), .o_pkt_err(a_pkt_err), .o_pkt_cnt(a_pkt_cnt),
    .o_err_cnt(a_err_cnt), .o_last_len(a_last_len), .o_err_flags(a_flags));

  axis_pkt_checker #(.P_MAX_BEATS(MAXB), .P_THROTTLE(1'b1), .P_CHECK_DATA(1'b1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_clr(clr),
    .s_axis_tdata(tdata), .s_axis_tuser(tuser), .s_axis_tkeep(tkeep),
    .s_axis_tlast(tlast), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
    .o_pkt_done(b_done), .o_pkt_err(b_pkt_err), .o_pkt_cnt(b_pkt_cnt),
    .o_err_cnt(b_err_cnt), .o_last_len(b_last_len), .o_err_flags(b_flags));

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: judge a whole packet from the rules, not beat-by-beat hardware state.
  function automatic exp_t model(input logic [31:0] u);
    exp_t e;
    int n, lim;
    logic [15:0] bk;
    n = pd.size();
    e = '{err: 1'b0, bits: 4'd0, len: 16'd0, len_chk: 1'b0, pcnt: 16'd0, ecnt: 16'd0, flags: 4'd0};
    lim = (n > MAXB) ? MAXB : n;
    for (int i = 0; i < lim; i++) begin
      bk = 16'(i + 1);
      if (pd[i] !== {4{bk}}) e.bits[0] = 1'b1;
      if (i == n - 1) begin
        if (!(pk[i] inside {8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80}))
          e.bits[1] = 1'b1;
      end else if (pk[i] !== 8'hFF) begin
        e.bits[1] = 1'b1;
      end
    end
    if (n > MAXB) begin
      e.bits[3] = 1'b1;
    end else begin
      e.len     = 16'(8 * (n - 1) + $countones(pk[n-1]));
      e.len_chk = 1'b1;
      if (e.len != u[15:0]) e.bits[2] = 1'b1;
    end
    e.err = |e.bits;
    return e;
  endfunction

  function automatic logic [15:0] good_len(input int n, input logic [7:0] lk);
    return 16'(8 * (n - 1) + $countones(lk));
  endfunction

  task automatic build_good(input int n, input logic [7:0] lk);
    logic [15:0] b;
    pd.delete();
    pk.delete();
    for (int i = 1; i <= n; i++) begin
      b = 16'(i);
      pd.push_back({4{b}});
      pk.push_back((i == n) ? lk : 8'hFF);
    end
  endtask

  task automatic zero_models();
    for (int i = 0; i < 2; i++) begin
      m_pcnt[i] = '0; m_ecnt[i] = '0; m_flags[i] = '0;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] kp, input logic l,
                           input logic [31:0] u, input logic c);
    int w;
    tdata = d; tkeep = kp; tlast = l; tuser = u; tvalid = 1'b1; clr = c;
    w = 0;
    @(negedge clk);
    while (!(sel ? b_tready : a_tready)) begin
      w++;
      if (w > 16) begin
        checks++; errors++;
        $display("FAIL ready_timeout: tready low for %0d cycles, required high within 16", w);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    if (l) due_q.push_back(cyc);
    tvalid = 1'b0; tlast = 1'b0; clr = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] u, input bit clr_last, input int gap_max);
    exp_t e;
    int s, n;
    e = model(u);
    s = sel ? 1 : 0;
    if (clr_last) begin
      zero_models();
    end else begin
      if (m_pcnt[s] != 16'hFFFF) m_pcnt[s]++;
      if (e.err && m_ecnt[s] != 16'hFFFF) m_ecnt[s]++;
      m_flags[s] |= e.bits;
    end
    e.pcnt = m_pcnt[s]; e.ecnt = m_ecnt[s]; e.flags = m_flags[s];
    sbq.push_back(e);
    n = pd.size();
    for (int i = 0; i < n; i++) begin
      send_beat(pd[i], pk[i], i == n - 1, u, clr_last && (i == n - 1));
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    check("sb_drain", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    zero_models();
    check("clr_a_pkt_cnt", a_pkt_cnt, 0);
    check("clr_a_err_cnt", a_err_cnt, 0);
    check("clr_a_flags", a_flags, 0);
    check("clr_b_pkt_cnt", b_pkt_cnt, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_tready"}, a_tready, 0);
    check({tag, "_b_tready"}, b_tready, 0);
    check({tag, "_a_done"}, a_done, 0);
    check({tag, "_a_err"}, a_pkt_err, 0);
    check({tag, "_a_pkt_cnt"}, a_pkt_cnt, 0);
    check({tag, "_a_err_cnt"}, a_err_cnt, 0);
    check({tag, "_a_last_len"}, a_last_len, 0);
    check({tag, "_a_flags"}, a_flags, 0);
    check({tag, "_b_pkt_cnt"}, b_pkt_cnt, 0);
    check({tag, "_b_flags"}, b_flags, 0);
  endtask

  // Monitor: every completion pops one expectation and must land on its due cycle.
  exp_t mon_e;
  int   mon_due;
  always @(negedge clk) begin
    if (!rst && (sel ? b_done : a_done)) begin
      if (sbq.size() == 0 || due_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL stray_done: o_pkt_done with no packet expected (cycle %0d)", cyc);
      end else begin
        mon_e   = sbq.pop_front();
        mon_due = due_q.pop_front();
        check("done_latency", cyc, mon_due);
        check("pkt_err", sel ? b_pkt_err : a_pkt_err, mon_e.err);
        check("err_flags", sel ? b_flags : a_flags, mon_e.flags);
        check("pkt_cnt", sel ? b_pkt_cnt : a_pkt_cnt, mon_e.pcnt);
        check("err_cnt", sel ? b_err_cnt : a_err_cnt, mon_e.ecnt);
        if (mon_e.len_chk) check("last_len", sel ? b_last_len : a_last_len, mon_e.len);
      end
    end
  end

  // tready: unthrottled instance always high, throttled one low exactly every fourth cycle.
  int last_low = -1, since_rst = 0;
  always @(negedge clk) begin
    if (rst) begin
      last_low  = -1;
      since_rst = 0;
    end else begin
      since_rst++;
      check("a_tready_high", a_tready, 1);
      if (!b_tready) begin
        if (last_low >= 0) check("thr_period", cyc - last_low, 4);
        last_low = cyc;
      end
      if (since_rst >= 5) check("thr_gap", (cyc - last_low) <= 3, 1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, j;
    logic [7:0]  lk;
    logic [31:0] u;
    zero_models();

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk); #1 rst = 1'b0;

    // Nominal 184-beat packet.
    sel = 1'b0;
    build_good(184, 8'h80);
    send_pkt(32'd1465, 1'b0, 0);
    drain();
    check("r20_pkt_cnt", a_pkt_cnt, 1);
    check("r20_last_len", a_last_len, 1465);
    check("r20_flags", a_flags, 0);

    // Data error on beat 10.
    do_clr();
    build_good(184, 8'h80);
    pd[9] = 64'h0;
    send_pkt(32'd1465, 1'b0, 0);
    drain();
    check("r21_err_cnt", a_err_cnt, 1);
    check("r21_flags", a_flags, 4'b0001);

    // Keep error, then length error.
    do_clr();
    build_good(184, 8'h80);
    pk[4] = 8'h7F;
    send_pkt(32'd1465, 1'b0, 0);
    build_good(184, 8'h80);
    send_pkt(32'd1472, 1'b0, 0);
    drain();
    check("r22_err_cnt", a_err_cnt, 2);
    check("r22_flags", a_flags, 4'b0110);
    check("r22_last_len", a_last_len, 1465);

    // Oversize boundary: 256 beats fits, 257 and 301 drop.
    do_clr();
    build_good(256, 8'hFF);
    send_pkt({16'h0, good_len(256, 8'hFF)}, 1'b0, 0);
    build_good(257, 8'hFF);
    send_pkt({16'h0, good_len(257, 8'hFF)}, 1'b0, 0);
    drain();
    do_clr();
    build_good(301, 8'hFF);
    send_pkt({16'h0, good_len(301, 8'hFF)}, 1'b0, 0);
    drain();
    check("r23_err_cnt", a_err_cnt, 1);
    check("r23_flags", a_flags, 4'b1000);

    // Clear coinciding with completion: pulse seen, packet not counted.
    build_good(3, 8'hF0);
    send_pkt({16'h0, good_len(3, 8'hF0)}, 1'b1, 0);
    drain();
    check("clr_coincide_cnt", a_pkt_cnt, 0);

    // Throttled instance, 20 back-to-back packets with all legal last keeps.
    sel = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n = $urandom_range(1, 4);
      build_good(n, kv[i % 8]);
      send_pkt({16'($urandom), good_len(n, kv[i % 8])}, 1'b0, 0);
    end
    drain();
    check("r24_pkt_cnt", b_pkt_cnt, 20);
    check("r24_err_cnt", b_err_cnt, 0);

    // Randomized packets with occasional injected faults on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int p = 0; p < 30; p++) begin
        n  = $urandom_range(1, 10);
        lk = ($urandom_range(0, 9) == 0) ? 8'($urandom) : kv[$urandom_range(0, 7)];
        build_good(n, lk);
        u = {16'($urandom), good_len(n, lk)};
        if ($urandom_range(0, 6) == 0) u[15:0] = 16'($urandom);
        if ($urandom_range(0, 6) == 0) begin
          j = $urandom_range(0, n - 1);
          pd[j] = pd[j] ^ (64'd1 << $urandom_range(0, 63));
        end
        if (n > 1 && $urandom_range(0, 6) == 0) pk[$urandom_range(0, n - 2)] = 8'h7F;
        send_pkt(u, 1'b0, 2);
      end
      drain();
    end

    // Reset in the middle of a packet, then a clean packet.
    sel = 1'b0;
    build_good(184, 8'h80);
    for (int i = 0; i < 89; i++) send_beat(pd[i], pk[i], 1'b0, 32'd1465, 1'b0);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    zero_models();
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    build_good(184, 8'h80);
    send_pkt(32'd1465, 1'b0, 0);
    drain();
    check("r25_pkt_cnt", a_pkt_cnt, 1);
    check("r25_err_cnt", a_err_cnt, 0);
    check("r25_flags", a_flags, 0);
    check("due_drain", due_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
